muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: Clk and Reset, with no other clock or reset inputs.
REQ-002 Parameter MULT_CYCLES, default 5: number of Busy cycles for MULT/MULTU.
REQ-003 Parameter DIV_CYCLES, default 10: number of Busy cycles for DIV/DIVU.
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  asynchronous, active-high; clears all state.
REQ-006 Start  input  1  E-stage instruction is a mult/div-unit operation this cycle.
REQ-007 Op  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-008 A  input  32  operand rs (dividend or multiplicand; MTHI/MTLO source).
REQ-009 B  input  32  operand rt (divisor or multiplier).
REQ-010 UseMD_D  input  1  D-stage instruction reads or writes HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
REQ-011 Busy  output  1  unit is executing a mult/div.
REQ-012 Stall  output  1  freeze F/D and bubble E, driven into the pipeline stall logic.
REQ-013 HI  output  32  HI register.
REQ-014 LO  output  32  LO register.

Function
REQ-015 States SHALL be IDLE and RUN, plus a down-counter wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-016 An operation SHALL be accepted only on a rising edge where Start=1 and Busy=0; Start while Busy=1 SHALL be ignored, with no state, HI or LO change.
REQ-017 On accepting MULT/MULTU/DIV/DIVU, the block SHALL latch Op, A and B, enter RUN and load the counter with MULT_CYCLES or DIV_CYCLES.
REQ-018 Busy SHALL equal 1 exactly in RUN, which is exactly N consecutive cycles starting the cycle after the accept edge (N = MULT_CYCLES or DIV_CYCLES).
REQ-019 On the edge that ends the Nth Busy cycle, the block SHALL update HI/LO and return to IDLE; HI/LO SHALL not change at any other point during RUN.
REQ-020 MULT: {HI,LO} SHALL equal the signed 64-bit product of A and B.
REQ-021 MULTU: {HI,LO} SHALL equal the unsigned 64-bit product of A and B.
REQ-022 DIV: LO SHALL equal the signed quotient truncated toward zero, and HI SHALL equal the remainder carrying the sign of the dividend.
REQ-023 DIVU: LO SHALL equal the unsigned quotient and HI the unsigned remainder.
REQ-024 DIV/DIVU with B=0 SHALL still hold Busy for DIV_CYCLES, then leave HI and LO unchanged.
REQ-025 MTHI/MTLO accepted in IDLE SHALL write A to HI/LO on the accept edge, with Busy staying 0.
REQ-026 Op 110/111 with Start=1 SHALL have no effect.
REQ-027 Stall SHALL equal UseMD_D & (Busy | (Start & (Op is MULT/MULTU/DIV/DIVU))), and SHALL be combinational.
REQ-028 Stall SHALL be 0 whenever UseMD_D=0, regardless of Busy.
REQ-029 Operands latched at accept SHALL be used; A/B changes during RUN SHALL have no effect.
REQ-030 A Start arriving on the same edge that completes RUN SHALL be ignored, because Busy=1 on that edge; it is accepted on the next edge if still asserted.

Reset
REQ-031 Reset=1 SHALL immediately, without waiting for a clock edge, force IDLE, counter=0, Busy=0, HI=0x00000000, LO=0x00000000.
REQ-032 Reset asserted during RUN SHALL abort the operation, with no HI/LO update after Reset is released.
REQ-033 Stall after reset SHALL follow REQ-027 using Busy=0.

Verification
REQ-034 MULT A=0xFFFFFFFF, B=0x00000002 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-035 MULTU A=0xFFFFFFFF, B=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles.
REQ-036 DIV A=0xFFFFFFF9 (-7), B=0x00000002 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-037 Start MULT, then Start DIV and MTHI (A=0x1234) in Busy cycle 2 -> both ignored; final result is the MULT only; UseMD_D=1 gives Stall=1 across all Busy cycles and 0 after.
REQ-038 HI=0xAAAA0000 preset via MTHI, then DIVU B=0 -> Busy 10 cycles, HI stays 0xAAAA0000 and LO is unchanged.
REQ-039 Reset pulsed in the 3rd Busy cycle of a DIV -> Busy, HI and LO go to 0 without a clock edge and stay 0 for 12 cycles after release.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//   Multi-cycle multiply/divide unit controller for a 5-stage MIPS-style
//   pipeline. It owns the HI/LO registers and makes mult/div appear to take
//   MULT_CYCLES / DIV_CYCLES cycles. While the unit is busy, any D-stage
//   instruction that touches HI/LO is stalled.
//
// Ports
//   Clk      in   1   rising-edge clock
//   Reset    in   1   asynchronous, active-high; clears all state
//   Start    in   1   E-stage instruction is a mult/div-unit operation
//   Op       in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                     100 MTHI, 101 MTLO, 110/111 no-op
//   A        in  32   rs operand (dividend / multiplicand / MTHI-MTLO source)
//   B        in  32   rt operand (divisor / multiplier)
//   UseMD_D  in   1   D-stage instruction reads or writes HI/LO
//   Busy     out  1   a mult/div is executing
//   Stall    out  1   freeze F/D and bubble E (combinational)
//   HI       out 32   HI register
//   LO       out 32   LO register
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        UseMD_D,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic               busy_q;

  logic [31:0]        hi_d;
  logic [31:0]        lo_d;
  logic [63:0]        mul_res;
  logic [63:0]        div_res;

  // Low 64 bits of the product of two 64-bit extended operands. Sign- or
  // zero-extension selects MULT vs MULTU, so one multiplier serves both.
  function automatic logic [63:0] mul_result(input logic        is_signed,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {{32{is_signed & a[31]}}, a};
    bx = {{32{is_signed & b[31]}}, b};
    return ax * bx;
  endfunction

  // Returns {remainder, quotient}. Signed division is done on magnitudes so
  // that -2^31 has a representable magnitude. The quotient is negated when the
  // operand signs differ (truncation toward zero). The remainder takes the
  // dividend's sign. A zero divisor yields 0 here; the caller discards it.
  function automatic logic [63:0] div_result(input logic        is_signed,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = is_signed & a[31];
    neg_b = is_signed & b[31];
    ma    = neg_a ? (32'd0 - a) : a;
    mb    = neg_b ? (32'd0 - b) : b;
    if (mb == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (neg_a ^ neg_b) q = 32'd0 - q;
    if (neg_a)         r = 32'd0 - r;
    return {r, q};
  endfunction

  // Results are formed from the operands latched at accept time. They are
  // committed only on the final RUN edge.
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_res = mul_result(op_q == OP_MULT, a_q, b_q);
    div_res = div_result(op_q == OP_DIV,  a_q, b_q);
    if (op_q == OP_MULT || op_q == OP_MULTU) begin
      hi_d = mul_res[63:32];
      lo_d = mul_res[31:0];
    end else if (b_q != 32'd0) begin
      hi_d = div_res[63:32];
      lo_d = div_res[31:0];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 3'b000;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            unique case (Op)
              OP_MULT, OP_MULTU: begin
                op_q    <= Op;
                a_q     <= A;
                b_q     <= B;
                cnt_q   <= CNT_W'(MULT_CYCLES);
                state_q <= RUN;
                busy_q  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                op_q    <= Op;
                a_q     <= A;
                b_q     <= B;
                cnt_q   <= CNT_W'(DIV_CYCLES);
                state_q <= RUN;
                busy_q  <= 1'b1;
              end
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          // Start is ignored in RUN, including on the completing edge.
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Op[2]==0 encodes exactly MULT/MULTU/DIV/DIVU.
  assign Stall = UseMD_D & (busy_q | (Start & ~Op[2]));
  assign Busy  = busy_q;
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        UseMD_D;
  logic        Busy;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .UseMD_D (UseMD_D),
    .Busy    (Busy),
    .Stall   (Stall),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drive one operation for a single accept edge; the expected {HI,LO}
  // goes onto the scoreboard when the stimulus is driven.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_hilo);
    sb_q.push_back(exp_hilo);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    tick();
    Start = 1'b0;
  endtask

  // Count Busy cycles (bounded), optionally checking Stall throughout, then
  // pop the scoreboard and compare HI/LO.
  task automatic wait_run(input string tag, input int n_exp, input logic chk_stall);
    int          n;
    logic        stall_ok;
    logic [63:0] exp_hilo;
    n        = 0;
    stall_ok = 1'b1;
    while (Busy === 1'b1 && n < 200) begin
      if (chk_stall && Stall !== 1'b1) stall_ok = 1'b0;
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(n_exp));
    if (chk_stall) begin
      chk({tag, "_stall_during"}, 64'(stall_ok), 64'(1));
      chk({tag, "_stall_after"}, 64'(Stall), 64'(0));
    end
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 64'(0), 64'(1));
    end else begin
      exp_hilo = sb_q.pop_front();
      chk({tag, "_hilo"}, {HI, LO}, exp_hilo);
    end
  endtask

  initial begin
    Reset   = 1'b1;
    Start   = 1'b0;
    Op      = 3'b000;
    A       = 32'd0;
    B       = 32'd0;
    UseMD_D = 1'b0;

    // Reset state and Stall while held in reset
    tick();
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_hilo", {HI, LO}, 64'd0);
    UseMD_D = 1'b1;
    #1;
    chk("rst_stall_idle", 64'(Stall), 64'(0));
    Start = 1'b1;
    Op    = 3'b000;
    #1;
    chk("rst_stall_start", 64'(Stall), 64'(1));
    Start = 1'b0;
    tick();
    Reset = 1'b0;

    // MULT / MULTU with Stall checked across all Busy cycles
    issue(3'b000, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE);
    wait_run("mult", 5, 1'b1);
    issue(3'b001, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE);
    wait_run("multu", 5, 1'b1);

    // DIV / DIVU; Stall must be 0 with UseMD_D=0 even while busy
    UseMD_D = 1'b0;
    issue(3'b010, 32'hFFFFFFF9, 32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD});
    chk("stall_md0_busy", 64'(Stall), 64'(0));
    wait_run("div_neg", 10, 1'b0);
    issue(3'b011, 32'd7, 32'd2, {32'd1, 32'd3});
    wait_run("divu", 10, 1'b0);
    issue(3'b010, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD});
    wait_run("div_negdiv", 10, 1'b0);

    // MULT with DIV and MTHI attempted while busy, operands changed mid-run
    UseMD_D = 1'b1;
    issue(3'b000, 32'd3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFF4);
    tick();
    Start = 1'b1;
    Op    = 3'b010;
    A     = 32'd100;
    B     = 32'd5;
    tick();
    Op    = 3'b100;
    A     = 32'h00001234;
    tick();
    Start = 1'b0;
    A     = 32'd5;
    B     = 32'd5;
    chk("ign_busy_mid", 64'(Busy), 64'(1));
    chk("ign_hilo_mid", {HI, LO}, {32'd1, 32'hFFFFFFFD});
    wait_run("mult_ign", 2, 1'b1);
    tick();
    chk("ign_no_late_accept", 64'(Busy), 64'(0));

    // Combinational Stall in IDLE
    Start = 1'b1;
    Op    = 3'b011;
    #1;
    chk("stall_comb_divu", 64'(Stall), 64'(1));
    Op = 3'b101;
    #1;
    chk("stall_comb_mtlo", 64'(Stall), 64'(0));
    Op = 3'b110;
    A  = 32'hDEADBEEF;
    #1;
    chk("stall_comb_nop", 64'(Stall), 64'(0));

    // Op 110 accepted edge: no effect
    tick();
    Start = 1'b0;
    chk("nop_busy", 64'(Busy), 64'(0));
    chk("nop_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFF4);

    // MTHI / MTLO then DIVU by zero leaves HI/LO
    Start = 1'b1;
    Op    = 3'b100;
    A     = 32'hAAAA0000;
    tick();
    chk("mthi_busy", 64'(Busy), 64'(0));
    chk("mthi_hilo", {HI, LO}, {32'hAAAA0000, 32'hFFFFFFF4});
    Op = 3'b101;
    A  = 32'h00005555;
    tick();
    Start = 1'b0;
    chk("mtlo_hilo", {HI, LO}, {32'hAAAA0000, 32'h00005555});
    issue(3'b011, 32'h00001234, 32'd0, {32'hAAAA0000, 32'h00005555});
    wait_run("divu_zero", 10, 1'b1);

    // Start held through the completing edge: ignored there, taken next edge
    UseMD_D = 1'b0;
    sb_q.push_back({32'd2, 32'd14});
    sb_q.push_back({32'd2, 32'd14});
    Start = 1'b1;
    Op    = 3'b011;
    A     = 32'd100;
    B     = 32'd7;
    tick();
    wait_run("divu_held", 10, 1'b0);
    tick();
    chk("held_reaccept", 64'(Busy), 64'(1));
    Start = 1'b0;
    wait_run("divu_again", 10, 1'b0);

    // Reset in the 3rd Busy cycle of a DIV: asynchronous clear, no late update
    Start = 1'b1;
    Op    = 3'b010;
    A     = 32'hFFFFFFF9;
    B     = 32'd2;
    tick();
    Start = 1'b0;
    tick();
    tick();
    chk("abort_busy_before", 64'(Busy), 64'(1));
    #2;
    Reset = 1'b1;
    #1;
    chk("abort_async_busy", 64'(Busy), 64'(0));
    chk("abort_async_hilo", {HI, LO}, 64'd0);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_post_busy", 64'(Busy), 64'(0));
      chk("abort_post_hilo", {HI, LO}, 64'd0);
    end

    chk("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
